// File: rtl/q5_pkg.sv
// Shared widths and defaults for the q5 select/register/transition-counter block.
package q5_pkg;

    localparam int N_IN      = 4;
    localparam int SEL_W     = 2;
    localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/q5_mux4.sv
// Purely combinational 4:1 select plus one-hot decode of the select; zero latency.
// No flow control: outputs follow d/s continuously, and an unknown select propagates as X.
module q5_mux4
    import q5_pkg::*;
(
    input  logic [N_IN-1:0]  d,
    input  logic [SEL_W-1:0] s,
    output logic             y,
    output logic [N_IN-1:0]  sel_oh
);

    always_comb begin
        y      = d[s];
        sel_oh = '0;
        for (int i = 0; i < N_IN; i++) begin
            sel_oh[i] = (s == SEL_W'(i));
        end
    end

endmodule

// File: rtl/q5.sv
// Muxed bit with registered copy (1-cycle load when EN) and saturating count of its transitions.
// No backpressure: EN=0 simply holds Y_Q and TCNT; RESET clears both asynchronously.
module q5
    import q5_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
)
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N_IN-1:0]  D,
    input  logic [SEL_W-1:0] S,
    input  logic             EN,
    output logic             Y,
    output logic             Y_Q,
    output logic [N_IN-1:0]  SEL_OH,
    output logic [CNT_W-1:0] TCNT
);

    q5_mux4 u_mux4 (
        .d      (D),
        .s      (S),
        .y      (Y),
        .sel_oh (SEL_OH)
    );

    // Only a real change of Y_Q counts; reloading the same value leaves TCNT alone.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            Y_Q  <= 1'b0;
            TCNT <= '0;
        end else if (EN && (Y != Y_Q)) begin
            Y_Q <= Y;
            if (TCNT != '1) begin
                TCNT <= TCNT + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_q5.sv
// Self-checking bench for q5: directed scenarios plus randomized traffic against a behavioural model.
module tb_q5;

    localparam int CW  = 8;
    localparam int MAX = (1 << CW) - 1;

    logic          CLK;
    logic          RESET;
    logic [3:0]    D;
    logic [1:0]    S;
    logic          EN;
    logic          Y;
    logic          Y_Q;
    logic [3:0]    SEL_OH;
    logic [CW-1:0] TCNT;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int ref_yq   = 0;
    int ref_tcnt = 0;

    q5 #(.CNT_W(CW)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .D      (D),
        .S      (S),
        .EN     (EN),
        .Y      (Y),
        .Y_Q    (Y_Q),
        .SEL_OH (SEL_OH),
        .TCNT   (TCNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic pick(input logic [3:0] dv, input int sv);
        return dv[sv];
    endfunction

    // Advance one rising edge, applying the transition/saturation rule to the model.
    task automatic cycle();
        int nv;
        @(posedge CLK);
        if (RESET) begin
            ref_yq   = 0;
            ref_tcnt = 0;
        end else if (EN) begin
            nv = int'(pick(D, int'(S)));
            if (nv != ref_yq) begin
                ref_yq   = nv;
                ref_tcnt = (ref_tcnt < MAX) ? ref_tcnt + 1 : MAX;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        ref_yq = 0;
        ref_tcnt = 0;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RESET = 1'b1;
        EN = 1'b1;
        D = 4'b1111;
        S = 2'd3;
        ref_yq = 0;
        ref_tcnt = 0;
        #1;
        checks++;
        if (Y_Q !== 1'b0 || TCNT !== '0) begin
            errors++;
            $display("FAIL reset_state: Y_Q=%b TCNT=%0d, required 0/0", Y_Q, TCNT);
        end
        cycle();
        checks++;
        if (Y_Q !== 1'b0 || TCNT !== '0) begin
            errors++;
            $display("FAIL reset_hold_en: Y_Q=%b TCNT=%0d, required 0/0", Y_Q, TCNT);
        end
        checks++;
        if (Y !== 1'b1) begin
            errors++;
            $display("FAIL reset_y_comb: Y=%b, required 1", Y);
        end
        @(negedge CLK);
        RESET = 1'b0;
        EN = 1'b0;
    endtask

    task automatic test_truth_table();
        logic [3:0] tv;
        @(negedge CLK);
        D = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            S = 2'(i);
            #1;
            tv = 4'b1011;
            checks++;
            if (Y !== tv[i]) begin
                errors++;
                $display("FAIL truth_y s=%0d: Y=%b, required %b", i, Y, tv[i]);
            end
            checks++;
            if (SEL_OH !== 4'(1 << i)) begin
                errors++;
                $display("FAIL truth_oh s=%0d: SEL_OH=%b, required %b", i, SEL_OH, 4'(1 << i));
            end
            #4;
        end
    endtask

    task automatic test_exhaustive();
        for (int k = 0; k < 64; k++) begin
            D = 4'(k >> 2);
            S = 2'(k);
            #1;
            checks++;
            if (Y !== pick(4'(k >> 2), k % 4)) begin
                errors++;
                $display("FAIL exhaustive D=%b S=%0d: Y=%b, required %b", D, S, Y, pick(4'(k >> 2), k % 4));
            end
        end
    endtask

    task automatic test_register_load();
        do_reset();
        @(negedge CLK);
        EN = 1'b1;
        D = 4'b0100;
        S = 2'd2;
        cycle();
        checks++;
        if (Y_Q !== 1'b1 || int'(TCNT) != 1) begin
            errors++;
            $display("FAIL load_one: Y_Q=%b TCNT=%0d, required 1/1", Y_Q, TCNT);
        end
        @(negedge CLK);
        EN = 1'b0;
        S = 2'd0;
        cycle();
        cycle();
        checks++;
        if (Y_Q !== 1'b1 || int'(TCNT) != 1) begin
            errors++;
            $display("FAIL load_hold: Y_Q=%b TCNT=%0d, required 1/1", Y_Q, TCNT);
        end
        // Reloading the same value must not count
        @(negedge CLK);
        EN = 1'b1;
        S = 2'd2;
        cycle();
        checks++;
        if (Y_Q !== 1'b1 || int'(TCNT) != 1) begin
            errors++;
            $display("FAIL load_same: Y_Q=%b TCNT=%0d, required 1/1", Y_Q, TCNT);
        end
        @(negedge CLK);
        EN = 1'b0;
    endtask

    task automatic test_counter_saturate();
        do_reset();
        @(negedge CLK);
        EN = 1'b1;
        D = 4'b0001;
        for (int c = 0; c < 300; c++) begin
            @(negedge CLK);
            S = 2'(c % 2);
            cycle();
            if (c == 100 || c == 254 || c == 255) begin
                checks++;
                if (int'(TCNT) != ref_tcnt || int'(Y_Q) != ref_yq) begin
                    errors++;
                    $display("FAIL count_c%0d: TCNT=%0d Y_Q=%b, required %0d/%0d", c, TCNT, Y_Q, ref_tcnt, ref_yq);
                end
            end
        end
        checks++;
        if (int'(TCNT) != MAX) begin
            errors++;
            $display("FAIL count_saturate: TCNT=%0d, required %0d", TCNT, MAX);
        end
        @(negedge CLK);
        EN = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        @(negedge CLK);
        EN = 1'b1;
        D = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            S = 2'(c % 2);
            cycle();
        end
        checks++;
        if (Y_Q !== 1'b1 || int'(TCNT) != 5) begin
            errors++;
            $display("FAIL areset_pre: Y_Q=%b TCNT=%0d, required 1/5", Y_Q, TCNT);
        end
        @(negedge CLK);
        EN = 1'b0;
        #2;
        RESET = 1'b1;
        ref_yq = 0;
        ref_tcnt = 0;
        #1;
        checks++;
        if (Y_Q !== 1'b0 || TCNT !== '0) begin
            errors++;
            $display("FAIL areset_immediate: Y_Q=%b TCNT=%0d, required 0/0", Y_Q, TCNT);
        end
        checks++;
        if (Y !== pick(D, int'(S))) begin
            errors++;
            $display("FAIL areset_y: Y=%b, required %b", Y, pick(D, int'(S)));
        end
        @(negedge CLK);
        RESET = 1'b0;
        EN = 1'b1;
        S = 2'd0;
        cycle();
        checks++;
        if (Y_Q !== 1'b1 || int'(TCNT) != 1) begin
            errors++;
            $display("FAIL areset_resume: Y_Q=%b TCNT=%0d, required 1/1", Y_Q, TCNT);
        end
        @(negedge CLK);
        EN = 1'b0;
    endtask

    task automatic test_x_select_hold();
        logic hq;
        logic [CW-1:0] hc;
        @(negedge CLK);
        hq = Y_Q;
        hc = TCNT;
        EN = 1'b0;
        S = 2'bxx;
        cycle();
        checks++;
        if (Y_Q !== hq || TCNT !== hc) begin
            errors++;
            $display("FAIL x_select_hold: Y_Q=%b TCNT=%0d, required %b/%0d", Y_Q, TCNT, hq, hc);
        end
        @(negedge CLK);
        S = 2'd0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            D  = 4'($urandom);
            S  = 2'($urandom);
            EN = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (Y !== pick(D, int'(S)) || SEL_OH !== 4'(1 << int'(S))) begin
                errors++;
                $display("FAIL rand_comb c=%0d: Y=%b SEL_OH=%b, required %b/%b", c, Y, SEL_OH, pick(D, int'(S)), 4'(1 << int'(S)));
            end
            cycle();
            checks++;
            if (int'(Y_Q) != ref_yq || int'(TCNT) != ref_tcnt) begin
                errors++;
                $display("FAIL rand_seq c=%0d: Y_Q=%b TCNT=%0d, required %0d/%0d", c, Y_Q, TCNT, ref_yq, ref_tcnt);
            end
        end
        @(negedge CLK);
        EN = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        EN = 1'b0;
        D = 4'b0000;
        S = 2'd0;
        test_reset();
        test_truth_table();
        test_exhaustive();
        test_register_load();
        test_counter_saturate();
        test_async_reset();
        test_x_select_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/q5.md
Q5 -- requirements
Module: q5

Interface
REQ-001 Parameter CNT_W, default 8, SHALL set the width of the transition counter TCNT.
REQ-002 CLK  input  1  system clock; all state updates SHALL occur on the rising edge.
REQ-003 RESET  input  1  reset; SHALL be asynchronous and active-high.
REQ-004 D  input  4  data inputs; D[0]..D[3] are the candidates for selection.
REQ-005 S  input  2  select; unsigned index 0..3 into D.
REQ-006 EN  input  1  load enable for the registered output.
REQ-007 Y  output  1  combinational multiplexer output.
REQ-008 Y_Q  output  1  registered copy of Y.
REQ-009 SEL_OH  output  4  combinational one-hot decode of S.
REQ-010 TCNT  output  CNT_W  saturating count of Y_Q transitions.

Function
REQ-011 Y SHALL equal D[S] at all times, with no clock dependency: S=0 gives D[0], S=1 gives D[1], S=2 gives D[2], S=3 gives D[3].
REQ-012 Y SHALL settle within one simulation delta of any change on D or S, and SHALL be valid well before 5 time units.
REQ-013 SEL_OH SHALL have exactly bit S set (S=2 gives 4'b0100), and SHALL be purely combinational.
REQ-014 On a rising CLK edge with EN=1, Y_Q SHALL load D[S] (one-cycle latency); with EN=0, Y_Q SHALL hold its value.
REQ-015 TCNT SHALL increment by 1 on each rising edge where Y_Q changes value, and SHALL saturate at all ones.
REQ-016 When EN=1 and the loaded value equals the current Y_Q, TCNT SHALL NOT change.
REQ-017 X or Z on S SHALL NOT be resolved as a defined select; Y may be X in that case, and no state SHALL be corrupted while EN=0.

Reset
REQ-018 Asserting RESET SHALL immediately, without waiting for a clock edge, force Y_Q=0 and TCNT=0.
REQ-019 While RESET=1, Y_Q and TCNT SHALL hold 0 regardless of EN.
REQ-020 Y and SHALL_OH are combinational and SHALL NOT be affected by RESET.
REQ-021 On the first rising edge after RESET deasserts, normal operation SHALL resume.
REQ-022 If RESET is asserted mid-count, TCNT SHALL return to 0 with no saturation memory.

Structure
REQ-023 A shared package q5_pkg SHALL hold N_IN=4, SEL_W=2, and the default CNT_W.
REQ-024 One sub-module, q5_mux4, SHALL implement the combinational selection and the one-hot decode.
REQ-025 q5 SHALL instantiate q5_mux4 and contain the Y_Q register and the TCNT counter.

Verification
REQ-026 Truth table: D=4'b1011, S stepped 0,1,2,3 with 5 time units per step -> Y=1,1,0,1 and SEL_OH=0001,0010,0100,1000.
REQ-027 Exhaustive combinational check: all 64 {D,S} combinations -> Y==D[S] for every row.
REQ-028 Register load: EN=1, D=4'b0100, S=2 -> Y_Q=1 one edge later; then EN=0 and S=0 -> Y_Q stays 1.
REQ-029 Counter: EN=1, D=4'b0001, S alternating 0/1 each cycle for 300 cycles with CNT_W=8 -> TCNT saturates at 255.
REQ-030 Async reset: assert RESET between clock edges while Y_Q=1 and TCNT=5 -> both read 0 before the next edge; Y still equals D[S].
